// File: rtl/dmem_arb_pkg.sv
// Shared codes for the data-memory arbiter: access sizes, store strobes, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] SEL_SB = 3'b001;
  localparam logic [2:0] SEL_SH = 3'b010;
  localparam logic [2:0] SEL_SW = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Number of bytes touched by an access; 0 flags the illegal size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Extracts a big-endian byte/half/word from a 32-bit read and sign/zero extends it.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import dmem_arb_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  // The addressed byte sits in the top lane, so narrow loads come from the MSBs.
  always_comb begin
    o_data = i_raw;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & i_raw[31]}}, i_raw[31:24]};
      SZ_HALF: o_data = {{16{i_signed & i_raw[31]}}, i_raw[31:16]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between the MEM stage and debug port in front of the data memory.
// Latency: done 1 edge after grant if illegal, 2 for stores, 3 for loads.
// Backpressure: one access in flight; requesters hold req until done, cpu_stall covers the MEM stage.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_size,
  input  logic        dbg_signed,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic        dbg_err,
  output logic [31:0] dbg_rdata,
  output logic        mem_rena,
  output logic        mem_wena,
  output logic [2:0]  mem_store_select,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      r_state, w_nxt_state;
  logic        r_last_grant, w_nxt_last_grant;
  logic        r_id, w_nxt_id;
  logic        r_we, w_nxt_we;
  logic        r_signed, w_nxt_signed;
  logic [1:0]  r_size, w_nxt_size;
  logic        r_cpu_done, w_nxt_cpu_done, r_cpu_err, w_nxt_cpu_err;
  logic [31:0] r_cpu_rdata, w_nxt_cpu_rdata;
  logic        r_dbg_done, w_nxt_dbg_done, r_dbg_err, w_nxt_dbg_err;
  logic [31:0] r_dbg_rdata, w_nxt_dbg_rdata;
  logic        r_mem_rena, w_nxt_mem_rena, r_mem_wena, w_nxt_mem_wena;
  logic [2:0]  r_mem_sel, w_nxt_mem_sel;
  logic [31:0] r_mem_addr, w_nxt_mem_addr, r_mem_wdata, w_nxt_mem_wdata;

  logic        w_cpu_elig, w_dbg_elig, w_any, w_gnt_id;
  logic        w_sel_we, w_sel_signed;
  logic [1:0]  w_sel_size;
  logic [31:0] w_sel_addr, w_sel_wdata, w_offset, w_ext;
  logic [32:0] w_end;
  logic        w_misalign, w_illegal;

  // A requester whose done is showing this cycle is masked so its re-request waits a cycle.
  assign w_cpu_elig = cpu_req & ~r_cpu_done;
  assign w_dbg_elig = dbg_req & ~r_dbg_done;
  assign w_any      = w_cpu_elig | w_dbg_elig;
  assign w_gnt_id   = (w_cpu_elig & w_dbg_elig) ? ~r_last_grant : w_dbg_elig;

  assign w_sel_we     = (w_gnt_id == REQ_DBG) ? dbg_we     : cpu_we;
  assign w_sel_size   = (w_gnt_id == REQ_DBG) ? dbg_size   : cpu_size;
  assign w_sel_signed = (w_gnt_id == REQ_DBG) ? dbg_signed : cpu_signed;
  assign w_sel_addr   = (w_gnt_id == REQ_DBG) ? dbg_addr   : cpu_addr;
  assign w_sel_wdata  = (w_gnt_id == REQ_DBG) ? dbg_wdata  : cpu_wdata;

  // Addresses below the base wrap to a huge offset; the 33-bit sum keeps the range check exact.
  assign w_offset   = w_sel_addr - BASE_ADDR;
  assign w_end      = {1'b0, w_offset} + {30'd0, size_bytes(w_sel_size)};
  assign w_misalign = ((w_sel_size == SZ_HALF) & w_sel_addr[0]) |
                      ((w_sel_size == SZ_WORD) & (w_sel_addr[1:0] != 2'b00));
  assign w_illegal  = (size_bytes(w_sel_size) == 3'd0) | w_misalign | (w_end > 33'(DEPTH));

  load_extend u_load_extend (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_raw    (mem_rdata),
    .o_data   (w_ext)
  );

  // Next-state and next-output logic; strobes and done pulses default to 0 every cycle.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_last_grant = r_last_grant;
    w_nxt_id         = r_id;
    w_nxt_we         = r_we;
    w_nxt_signed     = r_signed;
    w_nxt_size       = r_size;
    w_nxt_cpu_done   = 1'b0;
    w_nxt_cpu_err    = 1'b0;
    w_nxt_cpu_rdata  = 32'd0;
    w_nxt_dbg_done   = 1'b0;
    w_nxt_dbg_err    = 1'b0;
    w_nxt_dbg_rdata  = 32'd0;
    w_nxt_mem_rena   = 1'b0;
    w_nxt_mem_wena   = 1'b0;
    w_nxt_mem_sel    = 3'b000;
    w_nxt_mem_addr   = r_mem_addr;
    w_nxt_mem_wdata  = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nxt_id         = w_gnt_id;
          w_nxt_last_grant = w_gnt_id;
          w_nxt_we         = w_sel_we;
          w_nxt_size       = w_sel_size;
          w_nxt_signed     = w_sel_signed;
          if (w_illegal) begin
            if (w_gnt_id == REQ_DBG) begin
              w_nxt_dbg_done = 1'b1;
              w_nxt_dbg_err  = 1'b1;
            end else begin
              w_nxt_cpu_done = 1'b1;
              w_nxt_cpu_err  = 1'b1;
            end
          end else begin
            w_nxt_state     = ISSUE;
            w_nxt_mem_addr  = w_sel_addr;
            w_nxt_mem_wdata = w_sel_wdata;
            w_nxt_mem_rena  = ~w_sel_we;
            w_nxt_mem_wena  = w_sel_we;
            if (w_sel_we) begin
              case (w_sel_size)
                SZ_BYTE: w_nxt_mem_sel = SEL_SB;
                SZ_HALF: w_nxt_mem_sel = SEL_SH;
                default: w_nxt_mem_sel = SEL_SW;
              endcase
            end
          end
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_nxt_state = IDLE;
          if (r_id == REQ_DBG) w_nxt_dbg_done = 1'b1;
          else                 w_nxt_cpu_done = 1'b1;
        end else begin
          w_nxt_state = RWAIT;
        end
      end
      RWAIT: begin
        w_nxt_state = IDLE;
        if (r_id == REQ_DBG) begin
          w_nxt_dbg_done  = 1'b1;
          w_nxt_dbg_rdata = w_ext;
        end else begin
          w_nxt_cpu_done  = 1'b1;
          w_nxt_cpu_rdata = w_ext;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'b00;
      r_cpu_done   <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= 32'd0;
      r_dbg_done   <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dbg_rdata  <= 32'd0;
      r_mem_rena   <= 1'b0;
      r_mem_wena   <= 1'b0;
      r_mem_sel    <= 3'b000;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else begin
      r_state      <= w_nxt_state;
      r_last_grant <= w_nxt_last_grant;
      r_id         <= w_nxt_id;
      r_we         <= w_nxt_we;
      r_signed     <= w_nxt_signed;
      r_size       <= w_nxt_size;
      r_cpu_done   <= w_nxt_cpu_done;
      r_cpu_err    <= w_nxt_cpu_err;
      r_cpu_rdata  <= w_nxt_cpu_rdata;
      r_dbg_done   <= w_nxt_dbg_done;
      r_dbg_err    <= w_nxt_dbg_err;
      r_dbg_rdata  <= w_nxt_dbg_rdata;
      r_mem_rena   <= w_nxt_mem_rena;
      r_mem_wena   <= w_nxt_mem_wena;
      r_mem_sel    <= w_nxt_mem_sel;
      r_mem_addr   <= w_nxt_mem_addr;
      r_mem_wdata  <= w_nxt_mem_wdata;
    end
  end

  assign cpu_done         = r_cpu_done;
  assign cpu_err          = r_cpu_err;
  assign cpu_rdata        = r_cpu_rdata;
  assign cpu_stall        = cpu_req & ~r_cpu_done;
  assign dbg_done         = r_dbg_done;
  assign dbg_err          = r_dbg_err;
  assign dbg_rdata        = r_dbg_rdata;
  assign mem_rena         = r_mem_rena;
  assign mem_wena         = r_mem_wena;
  assign mem_store_select = r_mem_sel;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory, transaction-level reference model, directed + random traffic.
// Latency: n/a.
// Backpressure: requesters hold req until their done pulse.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;
  localparam int          NC    = 8000;
  localparam int          NTX   = 120;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, cpu_signed = 0;
  logic [1:0]  cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dbg_req = 0, dbg_we = 0, dbg_signed = 0;
  logic [1:0]  dbg_size = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic        cpu_done, cpu_err, cpu_stall, dbg_done, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_rena, mem_wena;
  logic [2:0]  mem_store_select;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_signed(dbg_signed),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .dbg_rdata(dbg_rdata),
    .mem_rena(mem_rena), .mem_wena(mem_wena), .mem_store_select(mem_store_select),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory seen by the DUT: the word returned starts at the addressed byte.
  bit [7:0]    mem_b [0:2047];
  logic [31:0] mdiff;
  logic [10:0] mo;
  assign mdiff = mem_addr - BASE;
  assign mo    = mdiff[10:0];

  always @(posedge clk) begin
    if (mem_wena && mdiff < DEPTH) begin
      case (mem_store_select)
        3'b001: mem_b[mo] <= mem_wdata[7:0];
        3'b010: begin
          mem_b[mo] <= mem_wdata[15:8];
          mem_b[mo + 11'd1] <= mem_wdata[7:0];
        end
        3'b100: begin
          mem_b[mo] <= mem_wdata[31:24];
          mem_b[mo + 11'd1] <= mem_wdata[23:16];
          mem_b[mo + 11'd2] <= mem_wdata[15:8];
          mem_b[mo + 11'd3] <= mem_wdata[7:0];
        end
        default: ;
      endcase
    end
    if (mem_rena)
      mem_rdata <= {mem_b[mo], mem_b[mo + 11'd1], mem_b[mo + 11'd2], mem_b[mo + 11'd3]};
  end

  // Reference model: a shadow memory plus per-cycle expected outputs scheduled at grant time.
  bit [7:0]  ref_mem [0:2047];
  bit        e_cd [NC];
  bit        e_ce [NC];
  bit [31:0] e_crd [NC];
  bit        e_dd [NC];
  bit        e_de [NC];
  bit [31:0] e_drd [NC];
  bit        e_ren [NC];
  bit        e_wen [NC];
  bit [2:0]  e_sel [NC];
  bit [31:0] e_addr [NC];
  bit [31:0] e_wd [NC];
  int        cyc = 0;
  int        free_at = 0;
  bit        m_last = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr(input int t);
    e_cd[t] = 0; e_ce[t] = 0; e_crd[t] = 0;
    e_dd[t] = 0; e_de[t] = 0; e_drd[t] = 0;
    e_ren[t] = 0; e_wen[t] = 0; e_sel[t] = 0; e_addr[t] = 0; e_wd[t] = 0;
  endtask

  task automatic model_step();
    bit        ce, de, g, we, sg, ill;
    bit [1:0]  sz;
    bit [31:0] ad, wd, off, v, raw;
    int        nb, lat, t;
    if (cyc < NC - 8) begin
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) clr(cyc + k);
        m_last  = 1'b1;
        free_at = cyc + 1;
      end
      chk("cpu_done", 32'(cpu_done), 32'(e_cd[cyc]));
      chk("cpu_err", 32'(cpu_err), 32'(e_ce[cyc]));
      chk("cpu_rdata", cpu_rdata, e_crd[cyc]);
      chk("dbg_done", 32'(dbg_done), 32'(e_dd[cyc]));
      chk("dbg_err", 32'(dbg_err), 32'(e_de[cyc]));
      chk("dbg_rdata", dbg_rdata, e_drd[cyc]);
      chk("mem_rena", 32'(mem_rena), 32'(e_ren[cyc]));
      chk("mem_wena", 32'(mem_wena), 32'(e_wen[cyc]));
      chk("mem_sel", 32'(mem_store_select), 32'(e_sel[cyc]));
      chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cd[cyc]));
      if (e_ren[cyc] || e_wen[cyc]) begin
        chk("mem_addr", mem_addr, e_addr[cyc]);
        chk("mem_wdata", mem_wdata, e_wd[cyc]);
      end
      if (rst_n && cyc >= free_at) begin
        ce = cpu_req && !e_cd[cyc];
        de = dbg_req && !e_dd[cyc];
        if (ce || de) begin
          g = (ce && de) ? !m_last : de;
          m_last = g;
          we = g ? dbg_we : cpu_we;
          sz = g ? dbg_size : cpu_size;
          sg = g ? dbg_signed : cpu_signed;
          ad = g ? dbg_addr : cpu_addr;
          wd = g ? dbg_wdata : cpu_wdata;
          nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
          off = ad - BASE;
          ill = (sz == 3) || (ad % nb != 0) || (longint'(off) + nb > DEPTH);
          v = 0;
          if (ill) begin
            lat = 1;
          end else begin
            if (we) begin
              lat = 2;
              e_wen[cyc + 1] = 1;
              e_sel[cyc + 1] = 3'(nb);
              for (int i = 0; i < nb; i++)
                ref_mem[11'(off + i)] = 8'(wd >> (8 * (nb - 1 - i)));
            end else begin
              lat = 3;
              e_ren[cyc + 1] = 1;
              raw = {ref_mem[11'(off)], ref_mem[11'(off + 1)], ref_mem[11'(off + 2)], ref_mem[11'(off + 3)]};
              v = raw >> (8 * (4 - nb));
              if (sg && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
            end
            e_addr[cyc + 1] = ad;
            e_wd[cyc + 1]   = wd;
          end
          t = cyc + lat;
          if (g) begin e_dd[t] = 1; e_de[t] = ill; e_drd[t] = v; end
          else   begin e_cd[t] = 1; e_ce[t] = ill; e_crd[t] = v; end
          free_at = t;
        end
      end
    end
    cyc++;
  endtask

  task automatic wait_step();
    @(posedge clk);
    #2;
  endtask

  // Runs one access on requester id and waits (bounded) for its done pulse.
  task automatic do_txn(input bit id, input bit we, input bit [1:0] sz, input bit sg,
                        input bit [31:0] ad, input bit [31:0] wd,
                        output bit [31:0] rd, output bit er, output int lat,
                        output bit [2:0] cap_sel, output bit [1:0] cap_str);
    bit got;
    got = 0; lat = 0; rd = 0; er = 0; cap_sel = 0; cap_str = 0;
    if (id) begin
      dbg_we = we; dbg_size = sz; dbg_signed = sg; dbg_addr = ad; dbg_wdata = wd; dbg_req = 1;
    end else begin
      cpu_we = we; cpu_size = sz; cpu_signed = sg; cpu_addr = ad; cpu_wdata = wd; cpu_req = 1;
    end
    while (!got && lat < 60) begin
      wait_step();
      lat++;
      if (lat == 1) begin cap_sel = mem_store_select; cap_str = {mem_wena, mem_rena}; end
      if (id ? dbg_done : cpu_done) begin
        got = 1;
        rd  = id ? dbg_rdata : cpu_rdata;
        er  = id ? dbg_err : cpu_err;
      end
    end
    if (id) dbg_req = 0; else cpu_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout requester %0d got no done expected done within 60 cycles", id);
    end
    wait_step();
  endtask

  task automatic rand_txn(output bit we, output bit [1:0] sz, output bit sg,
                          output bit [31:0] ad, output bit [31:0] wd);
    int r;
    we = 1'($urandom_range(0, 1));
    sg = 1'($urandom_range(0, 1));
    sz = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    wd = $urandom;
    r  = $urandom_range(0, 9);
    if (r == 0)      ad = BASE - $urandom_range(1, 16);
    else if (r == 1) ad = BASE + DEPTH - $urandom_range(0, 5);
    else             ad = BASE + $urandom_range(0, 63) * 4 +
                          (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
  endtask

  task automatic rand_port(input bit id);
    bit we, sg, er; bit [1:0] sz, cs; bit [31:0] ad, wd, rd; int lat; bit [2:0] csel;
    repeat (NTX) begin
      repeat ($urandom_range(0, 2)) wait_step();
      rand_txn(we, sz, sg, ad, wd);
      do_txn(id, we, sz, sg, ad, wd, rd, er, lat, csel, cs);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
      begin : main
        bit [31:0] rd; bit er; int lat, n; bit [2:0] cs; bit [1:0] st;
        int seq[$];
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_done", 32'({cpu_done, dbg_done, cpu_err, dbg_err}), 32'd0);
        chk("reset_strobes", 32'({mem_rena, mem_wena, mem_store_select}), 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        rst_n = 1;

        // Both held: CPU wins the first tie, then strict alternation.
        cpu_we = 1; cpu_size = 2; cpu_addr = BASE + 32'h100; cpu_wdata = 32'h0101_0101; cpu_req = 1;
        dbg_we = 1; dbg_size = 2; dbg_addr = BASE + 32'h200; dbg_wdata = 32'h0202_0202; dbg_req = 1;
        repeat (20) begin
          wait_step();
          if (cpu_done) seq.push_back(0);
          if (dbg_done) seq.push_back(1);
        end
        cpu_req = 0; dbg_req = 0;
        repeat (4) wait_step();
        chk("alt_count_ge8", 32'(seq.size() >= 8), 32'd1);
        for (int i = 0; i < seq.size(); i++) chk("alt_order", 32'(seq[i]), 32'(i % 2));

        do_txn(0, 1, 2, 0, BASE + 32'h10, 32'hDEAD_BEEF, rd, er, lat, cs, st);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_issue_sel", 32'(cs), 32'b100);
        chk("sw_issue_str", 32'(st), 32'b10);
        chk("sw_err", 32'(er), 32'd0);
        do_txn(0, 0, 2, 0, BASE + 32'h10, 32'h0, rd, er, lat, cs, st);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        chk("lw_lat", 32'(lat), 32'd3);
        chk("lw_issue_str", 32'(st), 32'b01);

        do_txn(1, 1, 1, 0, BASE + 32'h20, 32'h0000_807F, rd, er, lat, cs, st);
        chk("sh_issue_sel", 32'(cs), 32'b010);
        do_txn(0, 0, 0, 1, BASE + 32'h20, 0, rd, er, lat, cs, st);
        chk("lb", rd, 32'hFFFF_FF80);
        do_txn(0, 0, 0, 0, BASE + 32'h20, 0, rd, er, lat, cs, st);
        chk("lbu", rd, 32'h0000_0080);
        do_txn(0, 0, 1, 1, BASE + 32'h20, 0, rd, er, lat, cs, st);
        chk("lh", rd, 32'hFFFF_807F);
        do_txn(1, 0, 1, 0, BASE + 32'h20, 0, rd, er, lat, cs, st);
        chk("lhu", rd, 32'h0000_807F);

        do_txn(0, 0, 1, 1, BASE + 32'h1, 0, rd, er, lat, cs, st);
        chk("ill_lh_err", 32'({er, st}), 32'b100);
        chk("ill_lh_rd", rd, 32'd0);
        chk("ill_lh_lat", 32'(lat), 32'd1);
        do_txn(0, 0, 2, 0, BASE + 32'h402, 0, rd, er, lat, cs, st);
        chk("ill_lw_err", 32'({er, st}), 32'b100);
        chk("ill_lw_rd", rd, 32'd0);
        do_txn(1, 1, 2, 0, 32'h0, 32'h1234_5678, rd, er, lat, cs, st);
        chk("ill_sw_err", 32'({er, st}), 32'b100);
        chk("ill_sw_lat", 32'(lat), 32'd1);
        do_txn(0, 0, 2, 0, BASE + 32'h3FC, 0, rd, er, lat, cs, st);
        chk("edge_lw_err", 32'(er), 32'd0);

        do_txn(1, 1, 2, 0, BASE, 32'h1122_3344, rd, er, lat, cs, st);
        do_txn(1, 1, 0, 0, BASE + 32'h3, 32'h0000_00AB, rd, er, lat, cs, st);
        chk("sb_issue_sel", 32'(cs), 32'b001);
        do_txn(0, 0, 2, 0, BASE, 0, rd, er, lat, cs, st);
        chk("sb_merge", rd, 32'h1122_33AB);

        // Reset lands while a debug load waits for read data.
        dbg_we = 0; dbg_size = 2; dbg_signed = 0; dbg_addr = BASE; dbg_req = 1;
        wait_step();
        wait_step();
        rst_n = 0; dbg_req = 0;
        #1;
        chk("rst_mid_flags", 32'({cpu_done, cpu_err, dbg_done, dbg_err, mem_rena, mem_wena}), 32'd0);
        chk("rst_mid_rdata", cpu_rdata | dbg_rdata, 32'd0);
        chk("rst_mid_addr", mem_addr | mem_wdata, 32'd0);
        repeat (2) wait_step();
        rst_n = 1;
        n = 0;
        repeat (5) begin wait_step(); if (dbg_done) n++; end
        chk("rst_no_dbg_done", 32'(n), 32'd0);
        do_txn(0, 0, 2, 0, BASE, 0, rd, er, lat, cs, st);
        chk("post_rst_lw", rd, 32'h1122_33AB);
        chk("post_rst_lat", 32'(lat), 32'd3);

        fork
          rand_port(0);
          rand_port(1);
        join
        repeat (5) wait_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
